// File: rtl/ni_tx_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ni_tx_packetizer_if
//  Description : Bus bundle for the NI transmit packetizer. It carries the
//                AXI-lite write channel from the processing element and the
//                AXI-stream message channel to the router NI ingress port.
//  Ports       : s_aw*/s_w*/s_b*  AXI-lite write address, data and response
//                m_t*             AXI-stream message (PORT_WIDTH bits)
//  Modports    : slave  - packetizer view (AXI-lite slave, stream master)
//                master - processing element / router view
//  Revision    : 1.0  initial release
// ============================================================================
interface ni_tx_packetizer_if #(
  parameter int PORT_WIDTH = 128
);
  logic                  s_awvalid;
  logic                  s_awready;
  logic [4:0]            s_awaddr;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [31:0]           s_wdata;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [1:0]            s_bresp;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [PORT_WIDTH-1:0] m_tdata;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready, m_tready,
    output s_awready, s_wready, s_bvalid, s_bresp, m_tvalid, m_tdata
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready, m_tready,
    input  s_awready, s_wready, s_bvalid, s_bresp, m_tvalid, m_tdata
  );
endinterface
`default_nettype wire

// File: rtl/ni_tx_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : ni_tx_packetizer
//  Description : NI transmit stage. The processing element programs DST and
//                PL0..PL2 over AXI-lite; a write to SEND assembles a 128-bit
//                routing message (dst, src, seq, payload) and queues it in a
//                show-ahead TX FIFO that drains over an AXI-stream master.
//  Ports       : clk       clock
//                arst      synchronous active-high reset
//                bus       ni_tx_packetizer_if.slave (AXI-lite write + stream)
//                tx_level  TX FIFO occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module ni_tx_packetizer #(
  parameter int PORT_WIDTH = 128,
  parameter int TX_DEPTH   = 4,
  parameter int LOCAL_ADR  = 0,
  parameter int SIZE_X     = 4,
  parameter int SIZE_Y     = 4
) (
  input  logic                          clk,
  input  logic                          arst,
  ni_tx_packetizer_if.slave             bus,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_level
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(TX_DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);
  localparam logic [3:0]    SRC_X   = 4'(LOCAL_ADR / SIZE_Y);
  localparam logic [3:0]    SRC_Y   = 4'(LOCAL_ADR % SIZE_Y);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [4:0] ADDR_DST  = 5'h00;
  localparam logic [4:0] ADDR_PL0  = 5'h04;
  localparam logic [4:0] ADDR_PL1  = 5'h08;
  localparam logic [4:0] ADDR_PL2  = 5'h0C;
  localparam logic [4:0] ADDR_SEND = 5'h10;

  // Elaboration-time sanity checks on the parameter set.
  if (PORT_WIDTH != 128) begin : g_bad_width
    $error("ni_tx_packetizer: PORT_WIDTH must be 128");
  end
  if ((TX_DEPTH < 2) || ((TX_DEPTH & (TX_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ni_tx_packetizer: TX_DEPTH must be a power of 2, >= 2");
  end
  if (LOCAL_ADR >= SIZE_X * SIZE_Y) begin : g_bad_adr
    $error("ni_tx_packetizer: LOCAL_ADR outside the mesh");
  end

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  wstate_t         state;
  logic            bvalid;
  logic [1:0]      bresp;
  logic [7:0]      dst;
  logic [31:0]     pl0, pl1, pl2;
  logic [15:0]     seq;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [127:0]    mem [TX_DEPTH];

  logic            accept;
  logic            pop;
  logic            room;
  logic            push;
  logic [1:0]      resp;
  logic [127:0]    msg;

  // Address and data are only ever taken together, and never while reset
  // is asserted so that every output reads 0 during reset.
  assign accept = ~arst & (state == W_IDLE) & bus.s_awvalid & bus.s_wvalid;
  assign bus.s_awready = accept;
  assign bus.s_wready  = accept;
  assign bus.s_bvalid  = bvalid;
  assign bus.s_bresp   = bresp;

  assign bus.m_tvalid = (count != '0);
  assign bus.m_tdata  = mem[rd_ptr];
  assign tx_level     = count;

  assign pop = bus.m_tvalid & bus.m_tready;
  // A full FIFO can still take a message when the head leaves this cycle.
  assign room = (count < DEPTH_C) | pop;
  assign push = accept & (bus.s_awaddr == ADDR_SEND) & room;

  assign msg = {dst[3:0], dst[7:4], SRC_X, SRC_Y, seq, pl2, pl1, pl0};

  always_comb begin
    resp = RESP_DECERR;
    case (bus.s_awaddr)
      ADDR_DST, ADDR_PL0, ADDR_PL1, ADDR_PL2: resp = RESP_OKAY;
      ADDR_SEND: resp = room ? RESP_OKAY : RESP_SLVERR;
      default:   resp = RESP_DECERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state  <= W_IDLE;
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
      dst    <= '0;
      pl0    <= '0;
      pl1    <= '0;
      pl2    <= '0;
      seq    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        W_IDLE: begin
          if (accept) begin
            state  <= W_RESP;
            bvalid <= 1'b1;
            bresp  <= resp;
          end
        end
        W_RESP: begin
          if (bus.s_bready) begin
            state  <= W_IDLE;
            bvalid <= 1'b0;
          end
        end
        default: begin
          state  <= W_IDLE;
          bvalid <= 1'b0;
        end
      endcase

      if (accept) begin
        case (bus.s_awaddr)
          ADDR_DST: dst <= bus.s_wdata[7:0];
          ADDR_PL0: pl0 <= bus.s_wdata;
          ADDR_PL1: pl1 <= bus.s_wdata;
          ADDR_PL2: pl2 <= bus.s_wdata;
          default: ;
        endcase
      end

      if (push) begin
        seq    <= seq + 16'd1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= msg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ni_tx_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ni_tx_packetizer
//  Description : Scoreboard bench for ni_tx_packetizer. Stimulus tasks push
//                the expected write response and expected messages into
//                queues; a monitor pops and compares on every B and stream
//                handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ni_tx_packetizer;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [2:0] tx_level;

  int checks = 0;
  int errors = 0;

  logic [1:0]   bq [$];
  logic [127:0] tq [$];
  logic         post_tvalid;

  ni_tx_packetizer_if #(.PORT_WIDTH(128)) bus ();

  ni_tx_packetizer #(
    .PORT_WIDTH(128),
    .TX_DEPTH  (4),
    .LOCAL_ADR (0),
    .SIZE_X    (4),
    .SIZE_Y    (4)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .bus     (bus.slave),
    .tx_level(tx_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] d, input logic [15:0] s,
                                      input logic [31:0] p2, input logic [31:0] p1,
                                      input logic [31:0] p0);
    return {d[3:0], d[7:4], 4'h0, 4'h0, s, p2, p1, p0};
  endfunction

  // Monitor: compares each completed handshake against the scoreboard.
  always @(negedge clk) begin
    if (!arst) begin
      if (bus.s_bvalid && bus.s_bready) begin
        if (bq.size() == 0) check("bresp_unexpected", 128'(bus.s_bresp), 128'hX);
        else check("bresp", 128'(bus.s_bresp), 128'(bq.pop_front()));
      end
      if (bus.m_tvalid && bus.m_tready) begin
        if (tq.size() == 0) check("tdata_unexpected", bus.m_tdata, 128'hX);
        else check("tdata", bus.m_tdata, tq.pop_front());
      end
    end
  end

  // Full write transaction; bready is assumed high.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] exp);
    int n;
    bq.push_back(exp);
    bus.s_awaddr = addr;
    bus.s_wdata = data;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_awready && n < 20);
    if (!bus.s_awready) check("accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    @(negedge clk);
    post_tvalid = bus.m_tvalid;
    n = 0;
    while (!(bus.s_bvalid && bus.s_bready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(bus.s_bvalid && bus.s_bready)) check("bresp_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    bus.m_tready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_level != 0 && n < 50);
    @(posedge clk); #1;
    bus.m_tready = 1'b0;
    check("drain_level", 128'(tx_level), 128'd0);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_awvalid = 1'b0;
    bus.s_awaddr  = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_wdata   = '0;
    bus.s_bready  = 1'b1;
    bus.m_tready  = 1'b0;
    bus.s_awvalid = 1'b1;   // valid during reset must not be accepted
    bus.s_wvalid  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 128'(bus.s_awready), 128'd0);
    check("rst_bvalid",  128'(bus.s_bvalid),  128'd0);
    check("rst_tvalid",  128'(bus.m_tvalid),  128'd0);
    check("rst_level",   128'(tx_level),      128'd0);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    arst = 1'b0;

    // T1: basic message assembly and SEND-to-valid latency
    axi_write(5'h00, 32'h0000_0021, 2'b00);
    axi_write(5'h04, 32'h0000_000A, 2'b00);
    axi_write(5'h08, 32'h0000_000B, 2'b00);
    axi_write(5'h0C, 32'h0000_000C, 2'b00);
    tq.push_back(128'h1200_0000_0000_000C_0000_000B_0000_000A);
    axi_write(5'h10, 32'h0, 2'b00);
    check("t1_tvalid_latency", 128'(post_tvalid), 128'd1);
    check("t1_level", 128'(tx_level), 128'd1);
    drain();

    // T2: fill to depth, fifth SEND rejected
    do_reset();
    axi_write(5'h00, 32'hFFFF_FF35, 2'b00);
    axi_write(5'h04, 32'h1111_1111, 2'b00);
    axi_write(5'h08, 32'h2222_2222, 2'b00);
    axi_write(5'h0C, 32'h3333_3333, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tq.push_back(mk(8'h35, 16'(i), 32'h3333_3333, 32'h2222_2222, 32'h1111_1111));
      axi_write(5'h10, 32'h0, 2'b00);
    end
    axi_write(5'h10, 32'h0, 2'b10);
    check("t2_level_full", 128'(tx_level), 128'd4);
    check("t2_tvalid", 128'(bus.m_tvalid), 128'd1);

    // T3: SEND into a full FIFO in the same cycle as a pop
    bq.push_back(2'b00);
    tq.push_back(mk(8'h35, 16'd4, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111));
    bus.s_awaddr = 5'h10;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid = 1'b1;
    bus.m_tready = 1'b1;
    @(negedge clk);
    check("t3_accept", 128'(bus.s_awready), 128'd1);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    bus.m_tready = 1'b0;
    @(negedge clk);
    check("t3_level", 128'(tx_level), 128'd4);
    @(posedge clk); #1;
    drain();

    // T4: decode error, then address without data waits
    axi_write(5'h14, 32'hDEAD_BEEF, 2'b11);
    check("t4_no_push", 128'(tx_level), 128'd0);
    bus.s_awaddr = 5'h00;
    bus.s_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_awready_lone", 128'(bus.s_awready), 128'd0);
      @(posedge clk); #1;
    end
    check("t4_fsm_idle", 128'(bus.s_bvalid), 128'd0);
    bq.push_back(2'b00);
    bus.s_wdata = 32'h0000_0047;
    bus.s_wvalid = 1'b1;
    @(negedge clk);
    check("t4_awready_pair", 128'(bus.s_awready), 128'd1);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    // Payload persists, DST updated, seq continues at 5
    tq.push_back(mk(8'h47, 16'd5, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111));
    axi_write(5'h10, 32'h0, 2'b00);
    drain();

    // T5: sequence number wrap
    force dut.seq = 16'hFFFF;
    @(posedge clk); #1;
    release dut.seq;
    tq.push_back(mk(8'h47, 16'hFFFF, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111));
    axi_write(5'h10, 32'h0, 2'b00);
    tq.push_back(mk(8'h47, 16'h0000, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111));
    axi_write(5'h10, 32'h0, 2'b00);
    drain();

    // T6: reset while a response is pending and two messages are queued
    tq.push_back(mk(8'h47, 16'd1, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111));
    axi_write(5'h10, 32'h0, 2'b00);
    tq.push_back(mk(8'h47, 16'd2, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111));
    axi_write(5'h10, 32'h0, 2'b00);
    check("t6_level_pre", 128'(tx_level), 128'd2);
    bus.s_bready = 1'b0;
    bus.s_awaddr = 5'h04;
    bus.s_wdata = 32'h0000_0099;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    @(negedge clk);
    check("t6_bvalid_pending", 128'(bus.s_bvalid), 128'd1);
    @(posedge clk); #1;
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    tq.delete();
    @(negedge clk);
    check("t6_bvalid", 128'(bus.s_bvalid), 128'd0);
    check("t6_tvalid", 128'(bus.m_tvalid), 128'd0);
    check("t6_level",  128'(tx_level),     128'd0);
    bus.s_bready = 1'b1;
    @(posedge clk); #1;
    // Registers and seq cleared by reset
    tq.push_back(128'h0);
    axi_write(5'h10, 32'h0, 2'b00);
    drain();

    check("bq_empty", 128'(bq.size()), 128'd0);
    check("tq_empty", 128'(tq.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
